// File: rtl/cf_math_pkg.sv
// Minimal subset of the common_cells math helpers used for index and count widths.
package cf_math_pkg;

  // Bits needed to address num_idx entries; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/dummy_req_pkg.sv
// Shared types and the round-robin mask helper for the request collector.
package dummy_req_pkg;

  localparam int unsigned NumReq   = 32'd8;
  localparam int unsigned IdxWidth = cf_math_pkg::idx_width(NumReq);
  // Widest request vector rr_mask can describe; callers truncate to their own width.
  localparam int unsigned MaxReq   = 32'd64;

  typedef logic [IdxWidth-1:0] req_idx_t;

  // All bits strictly above last; empty once last is the top index.
  function automatic logic [MaxReq-1:0] rr_mask(input int unsigned last);
    return {MaxReq{1'b1}} << (last + 32'd1);
  endfunction

endpackage

// File: rtl/dummy_rr_pick.sv
// Combinational round-robin pick: lowest pending bit above last, else lowest pending bit.
module dummy_rr_pick
  import dummy_req_pkg::*;
#(
  parameter int unsigned NumReq   = dummy_req_pkg::NumReq,
  parameter int unsigned IdxWidth = cf_math_pkg::idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   pend_i,
  input  logic [IdxWidth-1:0] last_i,
  output logic [IdxWidth-1:0] pick_o,
  output logic                any_o
);

  logic [NumReq-1:0]   mask_s;
  logic [NumReq-1:0]   masked_s;
  logic [IdxWidth-1:0] cnt_masked_s;
  logic [IdxWidth-1:0] cnt_all_s;
  logic                empty_masked_s;
  logic                empty_all_s;

  assign mask_s   = NumReq'(rr_mask(32'(last_i)));
  assign masked_s = pend_i & mask_s;

  lzc #(
    .WIDTH    (NumReq),
    .MODE     (1'b0),
    .CNT_WIDTH(IdxWidth)
  ) i_lzc_masked (
    .in_i   (masked_s),
    .cnt_o  (cnt_masked_s),
    .empty_o(empty_masked_s)
  );

  lzc #(
    .WIDTH    (NumReq),
    .MODE     (1'b0),
    .CNT_WIDTH(IdxWidth)
  ) i_lzc_all (
    .in_i   (pend_i),
    .cnt_o  (cnt_all_s),
    .empty_o(empty_all_s)
  );

  assign pick_o = empty_masked_s ? cnt_all_s : cnt_masked_s;
  assign any_o  = ~empty_all_s;

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter compatible with the common_cells lzc interface.
module lzc #(
  parameter int unsigned WIDTH     = 32'd2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // MODE 0 returns the lowest set bit, MODE 1 the count of leading zeros.
  always_comb begin
    cnt_o = '0;
    if (MODE) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in_i[i]) begin
          cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
        end else begin
          cnt_o = cnt_o;
        end
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in_i[i]) begin
          cnt_o = CNT_WIDTH'(i);
        end else begin
          cnt_o = cnt_o;
        end
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/dummy_req_collector.sv
// Sticky request collector presenting one round-robin granted index per valid/ready handshake.
module dummy_req_collector
  import dummy_req_pkg::*;
#(
  parameter int unsigned NumReq   = 32'd8,
  parameter int unsigned IdxWidth = cf_math_pkg::idx_width(NumReq),
  parameter int unsigned CntWidth = cf_math_pkg::idx_width(NumReq + 32'd1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [NumReq-1:0]   req_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic [NumReq-1:0]   pending_o,
  output logic [CntWidth-1:0] count_o,
  output logic                dropped_o
);

  localparam logic [NumReq-1:0]   OneHot  = {{(NumReq-1){1'b0}}, 1'b1};
  localparam logic [IdxWidth-1:0] LastRst = IdxWidth'(NumReq - 32'd1);

  logic [NumReq-1:0]   pend_q, pend_d;
  logic                valid_q, valid_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [IdxWidth-1:0] last_q, last_d;
  logic                drop_q, drop_d;
  logic [CntWidth-1:0] count_s;

  logic [IdxWidth-1:0] pick_s;
  logic                any_s;
  logic                load_s;
  logic [NumReq-1:0]   clr_mask_s;

  dummy_rr_pick #(
    .NumReq  (NumReq),
    .IdxWidth(IdxWidth)
  ) i_pick (
    .pend_i(pend_q),
    .last_i(last_q),
    .pick_o(pick_s),
    .any_o (any_s)
  );

  assign load_s     = ~valid_q | ready_i;
  assign clr_mask_s = (load_s && any_s) ? (OneHot << pick_s) : '0;

  // Next state: clear flushes everything; otherwise set-wins pending update and optional grant.
  always_comb begin
    pend_d  = (pend_q & ~clr_mask_s) | req_i;
    drop_d  = |(req_i & pend_q & ~clr_mask_s);
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (clear_i) begin
      pend_d  = '0;
      drop_d  = 1'b0;
      valid_d = 1'b0;
      idx_d   = '0;
      last_d  = LastRst;
    end else if (load_s) begin
      valid_d = any_s;
      if (any_s) begin
        idx_d  = pick_s;
        last_d = pick_s;
      end else begin
        idx_d  = idx_q;
        last_d = last_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= LastRst;
      drop_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  // Population count of the registered pending vector.
  always_comb begin
    count_s = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      count_s = count_s + CntWidth'(pend_q[k]);
    end
  end

  assign valid_o   = valid_q;
  assign idx_o     = idx_q;
  assign pending_o = pend_q;
  assign count_o   = count_s;
  assign dropped_o = drop_q;

endmodule

// File: tb/tb_dummy_req_collector.sv
// Directed bench for dummy_req_collector with hand-computed expected outputs (NumReq=8).
module tb_dummy_req_collector;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clear_i;
  logic [7:0] req_i;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] idx_o;
  logic [7:0] pending_o;
  logic [3:0] count_o;
  logic       dropped_o;

  int checks_q   = 0;
  int failures_q = 0;

  dummy_req_collector #(.NumReq(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .req_i    (req_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .idx_o    (idx_o),
    .pending_o(pending_o),
    .count_o  (count_o),
    .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      failures_q++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] idx,
                            input logic [7:0] pend, input logic [3:0] cnt, input logic drop);
    check_eq({tag, ".valid"}, 32'(valid_o), 32'(v));
    if (v) check_eq({tag, ".idx"}, 32'(idx_o), 32'(idx));
    else   check_eq({tag, ".idx_hold"}, 32'(idx_o), 32'(idx));
    check_eq({tag, ".pending"}, 32'(pending_o), 32'(pend));
    check_eq({tag, ".count"}, 32'(count_o), 32'(cnt));
    check_eq({tag, ".dropped"}, 32'(dropped_o), 32'(drop));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; req_i = 8'h00; ready_i = 1'b0;
    #2;
    expect_out("reset", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    #10 rst_i = 1'b0;

    // Round-robin order 1,3,7
    ready_i = 1'b1; req_i = 8'h8A; tick(); expect_out("rr_load", 1'b0, 3'd0, 8'h8A, 4'd3, 1'b0);
    req_i = 8'h00; tick(); expect_out("rr_g1", 1'b1, 3'd1, 8'h88, 4'd2, 1'b0);
    tick(); expect_out("rr_g3", 1'b1, 3'd3, 8'h80, 4'd1, 1'b0);
    tick(); expect_out("rr_g7", 1'b1, 3'd7, 8'h00, 4'd0, 1'b0);
    tick(); expect_out("rr_idle", 1'b0, 3'd7, 8'h00, 4'd0, 1'b0);

    // Wrap fairness: after 5, bit 6 beats bit 2
    req_i = 8'h20; tick(); expect_out("wr_load5", 1'b0, 3'd7, 8'h20, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("wr_g5", 1'b1, 3'd5, 8'h00, 4'd0, 1'b0);
    req_i = 8'h44; tick(); expect_out("wr_load", 1'b0, 3'd5, 8'h44, 4'd2, 1'b0);
    req_i = 8'h00; tick(); expect_out("wr_g6", 1'b1, 3'd6, 8'h04, 4'd1, 1'b0);
    tick(); expect_out("wr_g2", 1'b1, 3'd2, 8'h00, 4'd0, 1'b0);
    tick(); expect_out("wr_idle", 1'b0, 3'd2, 8'h00, 4'd0, 1'b0);

    // Backpressure and drop on bit 4
    ready_i = 1'b0; req_i = 8'h10; tick(); expect_out("bp_load", 1'b0, 3'd2, 8'h10, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("bp_g4", 1'b1, 3'd4, 8'h00, 4'd0, 1'b0);
    req_i = 8'h10; tick(); expect_out("bp_p1", 1'b1, 3'd4, 8'h10, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("bp_hold", 1'b1, 3'd4, 8'h10, 4'd1, 1'b0);
    req_i = 8'h10; tick(); expect_out("bp_drop", 1'b1, 3'd4, 8'h10, 4'd1, 1'b1);
    req_i = 8'h00; tick(); expect_out("bp_nodrop", 1'b1, 3'd4, 8'h10, 4'd1, 1'b0);
    ready_i = 1'b1; tick(); expect_out("bp_regrant4", 1'b1, 3'd4, 8'h00, 4'd0, 1'b0);
    tick(); expect_out("bp_idle", 1'b0, 3'd4, 8'h00, 4'd0, 1'b0);

    // Set wins over clear on bit 3
    req_i = 8'h08; tick(); expect_out("sw_load", 1'b0, 3'd4, 8'h08, 4'd1, 1'b0);
    req_i = 8'h08; tick(); expect_out("sw_g3", 1'b1, 3'd3, 8'h08, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("sw_g3again", 1'b1, 3'd3, 8'h00, 4'd0, 1'b0);
    tick(); expect_out("sw_idle", 1'b0, 3'd3, 8'h00, 4'd0, 1'b0);

    // Clear priority over a live grant and req=FF
    req_i = 8'h01; tick(); expect_out("cl_load", 1'b0, 3'd3, 8'h01, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("cl_g0", 1'b1, 3'd0, 8'h00, 4'd0, 1'b0);
    clear_i = 1'b1; req_i = 8'hFF; tick(); expect_out("cl_flush", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    clear_i = 1'b0; req_i = 8'h00; tick(); expect_out("cl_after1", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    tick(); expect_out("cl_after2", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);

    // Asynchronous reset mid-stream with P=A5
    ready_i = 1'b0; req_i = 8'h01; tick(); expect_out("rs_load", 1'b0, 3'd0, 8'h01, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("rs_g0", 1'b1, 3'd0, 8'h00, 4'd0, 1'b0);
    req_i = 8'hA5; tick(); expect_out("rs_pa5", 1'b1, 3'd0, 8'hA5, 4'd4, 1'b0);
    req_i = 8'h00;
    #2 rst_i = 1'b1;
    #1 expect_out("rs_async", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    #3 rst_i = 1'b0;
    ready_i = 1'b1; req_i = 8'h02; tick(); expect_out("rs_lat1", 1'b0, 3'd0, 8'h02, 4'd1, 1'b0);
    req_i = 8'h00; tick(); expect_out("rs_lat2", 1'b1, 3'd1, 8'h00, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

endmodule
